// File: rtl/mem_access_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_pkg
// Shared types and constants for the MEM-stage memory access controller.
//   state_e   : controller FSM state encoding
//   DATA_W    : data bus width
//   ADDR_W    : address bus width
//   sat_inc32 : 32-bit increment that sticks at all-ones
// ---------------------------------------------------------------------------
package mem_access_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// ---------------------------------------------------------------------------
// mem_wait_timer
// Saturating up-counter that measures how long the controller has been
// waiting for a memory acknowledge.
//   clk_i    in   clock
//   rst_i    in   synchronous active-high reset
//   clear    in   force the count to zero (priority over enable)
//   enable   in   advance the count by one, sticking at TIMEOUT
//   expired  out  count has reached TIMEOUT
// ---------------------------------------------------------------------------
module mem_wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] count;

    // Counting stops at LIMIT, so the counter can never wrap back to zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
// MEM-stage sequencer for a variable-latency data memory. Turns the
// MemRead/MemWrite controls into a req/ack transaction, freezes the upstream
// pipeline while it is outstanding and hands the load data to MEM/WB.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no transaction; a memory op here stalls and latches request
//   ACCESS | request held to memory, waiting for ack or timeout
//   DONE   | transaction finished; pipeline advances this cycle
//
// Ports
//   clk_i, rst_i               clock, synchronous active-high reset
//   MemRead_i, MemWrite_i      MEM-stage controls from EX/MEM
//   Addr_i, WriteData_i        address and store data from EX/MEM
//   mem_req_o, mem_we_o        registered request and write flag to memory
//   mem_addr_o, mem_wdata_o    latched address and store data
//   mem_ack_i, mem_rdata_i     completion pulse and read data from memory
//   ReadData_o                 load data to MEM/WB
//   stall_o, memwb_en_o        pipeline freeze and MEM/WB enable
//   timeout_o                  sticky flag: a transaction was aborted
//   stall_cnt_o                saturating count of stalled cycles
// ---------------------------------------------------------------------------
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [ADDR_W-1:0] Addr_i,
    input  logic [DATA_W-1:0] WriteData_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [DATA_W-1:0] ReadData_o,
    output logic              stall_o,
    output logic              memwb_en_o,
    output logic              timeout_o,
    output logic [31:0]       stall_cnt_o
);

    state_e state;
    logic   mem_op;
    logic   rw_both;
    logic   timer_clear;
    logic   timer_en;
    logic   timer_expired;

    assign mem_op     = MemRead_i | MemWrite_i;
    assign stall_o    = ((state == IDLE) && mem_op) || (state == ACCESS);
    assign memwb_en_o = ~stall_o;

    // The timer also counts the IDLE detect cycle, so during the k-th ACCESS
    // cycle it holds k. Checking expired in ACCESS therefore aborts at the end
    // of exactly TIMEOUT request cycles. Every non-stalled cycle (plain IDLE
    // and DONE) clears it, so each transaction starts from zero.
    assign timer_clear = ~stall_o;
    assign timer_en    = stall_o;

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            rw_both     <= 1'b0;
            ReadData_o  <= '0;
            timeout_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        mem_addr_o  <= Addr_i;
                        mem_wdata_o <= WriteData_i;
                        mem_we_o    <= MemWrite_i;
                        rw_both     <= MemRead_i & MemWrite_i;
                        mem_req_o   <= 1'b1;
                        state       <= ACCESS;
                    end
                end

                ACCESS: begin
                    if (mem_ack_i) begin
                        // A conflicting read+write runs as a write but must
                        // not leave stale load data for MEM/WB.
                        if (!mem_we_o) begin
                            ReadData_o <= mem_rdata_i;
                        end else if (rw_both) begin
                            ReadData_o <= '0;
                        end
                        mem_req_o <= 1'b0;
                        state     <= DONE;
                    end else if (timer_expired) begin
                        timeout_o  <= 1'b1;
                        ReadData_o <= '0;
                        mem_req_o  <= 1'b0;
                        state      <= DONE;
                    end
                end

                DONE: begin
                    // The next instruction is only evaluated once it sits in
                    // MEM, which is the following IDLE cycle.
                    state <= IDLE;
                end

                default: begin
                    mem_req_o <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
        end else if (stall_o) begin
            stall_cnt_o <= sat_inc32(stall_cnt_o);
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
// Directed checks of mem_access_ctrl with TIMEOUT=4: reset values, load with
// delayed ack, store, timeout abort, back-to-back loads, spurious ack,
// read+write conflict and reset during an outstanding access.
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] Addr_i;
    logic [31:0] WriteData_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] ReadData_o;
    logic        stall_o;
    logic        memwb_en_o;
    logic        timeout_o;
    logic [31:0] stall_cnt_o;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    mem_access_ctrl #(
        .TIMEOUT (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .Addr_i      (Addr_i),
        .WriteData_i (WriteData_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .ReadData_o  (ReadData_o),
        .stall_o     (stall_o),
        .memwb_en_o  (memwb_en_o),
        .timeout_o   (timeout_o),
        .stall_cnt_o (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues one MEM-stage op in an IDLE cycle and follows it to DONE.
    // ack_at: ACCESS cycle (1-based) in which memory acks; 0 = never.
    // Returns in the DONE cycle with the MEM-stage controls dropped.
    task automatic run_txn(input string tag, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int ack_at, input logic [31:0] rdata,
                           output int stalls, output int reqs);
        bit done;
        stalls = 0;
        reqs   = 0;
        done   = 1'b0;
        @(posedge clk_i); #1;
        MemRead_i   = rd;
        MemWrite_i  = wr;
        Addr_i      = addr;
        WriteData_i = wdata;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) begin
                @(posedge clk_i); #1;
            end
            if (mem_req_o) begin
                reqs++;
                mem_ack_i   = (reqs == ack_at);
                mem_rdata_i = (reqs == ack_at) ? rdata : 32'hBAD0_BAD0;
            end else begin
                mem_ack_i = 1'b0;
            end
            #1;
            if (mem_req_o && reqs == 1) begin
                check({tag, "_we"}, 32'(mem_we_o), 32'(wr));
                check({tag, "_addr"}, mem_addr_o, addr);
                if (wr) check({tag, "_wdata"}, mem_wdata_o, wdata);
            end
            if (stall_o) begin
                stalls++;
            end else if (c > 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check({tag, "_bound"}, 32'd0, 32'd1);
        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
        mem_ack_i  = 1'b0;
        check({tag, "_done_req"}, 32'(mem_req_o), 32'd0);
        check({tag, "_done_memwb_en"}, 32'(memwb_en_o), 32'd1);
    endtask

    initial begin
        int st, rq, cyc_a, cyc_b;
        rst_i       = 1'b1;
        MemRead_i   = 1'b0;
        MemWrite_i  = 1'b0;
        Addr_i      = '0;
        WriteData_i = '0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;

        // Reset values
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_req", 32'(mem_req_o), 32'd0);
        check("rst_we", 32'(mem_we_o), 32'd0);
        check("rst_addr", mem_addr_o, 32'd0);
        check("rst_wdata", mem_wdata_o, 32'd0);
        check("rst_rdata", ReadData_o, 32'd0);
        check("rst_timeout", 32'(timeout_o), 32'd0);
        check("rst_stall_cnt", stall_cnt_o, 32'd0);
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_memwb_en", 32'(memwb_en_o), 32'd1);
        rst_i = 1'b0;

        // Load, ack on the 3rd ACCESS cycle
        run_txn("ld", 1'b1, 1'b0, 32'h0000_0100, 32'h0, 3, 32'hDEAD_BEEF, st, rq);
        check("ld_stalls", 32'(st), 32'd4);
        check("ld_reqs", 32'(rq), 32'd3);
        check("ld_rdata", ReadData_o, 32'hDEAD_BEEF);
        check("ld_stall_cnt", stall_cnt_o, 32'd4);
        check("ld_timeout", 32'(timeout_o), 32'd0);

        // Store, immediate ack
        run_txn("st", 1'b0, 1'b1, 32'h0000_0200, 32'h1234_5678, 1, 32'h0, st, rq);
        check("st_stalls", 32'(st), 32'd2);
        check("st_reqs", 32'(rq), 32'd1);
        check("st_rdata_kept", ReadData_o, 32'hDEAD_BEEF);
        check("st_stall_cnt", stall_cnt_o, 32'd6);

        // Load with no ack: timeout after 4 request cycles
        run_txn("to", 1'b1, 1'b0, 32'h0000_0300, 32'h0, 0, 32'h0, st, rq);
        check("to_reqs", 32'(rq), 32'd4);
        check("to_stalls", 32'(st), 32'd5);
        check("to_flag", 32'(timeout_o), 32'd1);
        check("to_rdata", ReadData_o, 32'd0);
        check("to_stall_cnt", stall_cnt_o, 32'd11);

        // Back-to-back loads, no bubbles beyond the 3-cycle FSM
        run_txn("b2b0", 1'b1, 1'b0, 32'h0000_0010, 32'h0, 1, 32'h1111_1111, st, rq);
        cyc_a = cyc;
        check("b2b0_stalls", 32'(st), 32'd2);
        check("b2b0_rdata", ReadData_o, 32'h1111_1111);
        run_txn("b2b1", 1'b1, 1'b0, 32'h0000_0014, 32'h0, 1, 32'h2222_2222, st, rq);
        cyc_b = cyc;
        check("b2b1_stalls", 32'(st), 32'd2);
        check("b2b1_rdata", ReadData_o, 32'h2222_2222);
        check("b2b_spacing", 32'(cyc_b - cyc_a), 32'd3);
        check("b2b_stall_cnt", stall_cnt_o, 32'd15);
        check("timeout_sticky", 32'(timeout_o), 32'd1);

        // Spurious ack in IDLE
        @(posedge clk_i); #1;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h5555_5555;
        #1;
        check("spur_stall", 32'(stall_o), 32'd0);
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
        check("spur_req", 32'(mem_req_o), 32'd0);
        check("spur_rdata", ReadData_o, 32'h2222_2222);
        check("spur_stall_cnt", stall_cnt_o, 32'd15);

        // MemRead and MemWrite both high: runs as a write, load data cleared
        run_txn("rw", 1'b1, 1'b1, 32'h0000_0400, 32'hCAFE_F00D, 1, 32'h9999_9999, st, rq);
        check("rw_stalls", 32'(st), 32'd2);
        check("rw_rdata", ReadData_o, 32'd0);
        check("rw_stall_cnt", stall_cnt_o, 32'd17);

        // Reset on the 2nd ACCESS cycle, then a late ack
        @(posedge clk_i); #1;
        MemRead_i = 1'b1;
        Addr_i    = 32'h0000_0500;
        @(posedge clk_i); #1;
        check("rr_req_acc1", 32'(mem_req_o), 32'd1);
        @(posedge clk_i); #1;
        rst_i     = 1'b1;
        MemRead_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        check("rr_req", 32'(mem_req_o), 32'd0);
        check("rr_we", 32'(mem_we_o), 32'd0);
        check("rr_addr", mem_addr_o, 32'd0);
        check("rr_timeout", 32'(timeout_o), 32'd0);
        check("rr_stall_cnt", stall_cnt_o, 32'd0);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h7777_7777;
        #1;
        check("rr_stall", 32'(stall_o), 32'd0);
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
        check("rr_late_ack_rdata", ReadData_o, 32'd0);
        check("rr_late_ack_req", 32'(mem_req_o), 32'd0);
        check("rr_late_ack_stall_cnt", stall_cnt_o, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencing controller for the MEM stage of the five-stage pipeline when data memory has variable latency. It converts the MEM-stage MemRead/MemWrite control signals into a req/ack memory transaction. While the transaction is outstanding it freezes the pipeline: stall_o holds PC, IF/ID, ID/EX and EX/MEM, and memwb_en_o drives the MEM/WB register enable (start_i). It returns the read data that MEM/WB captures on MemRead_Data_i.

## Interface
- TIMEOUT, 255: max ACCESS cycles waiting for ack before abort (1..65535)
- clk_i  in  1  clock, all logic on posedge
- rst_i  in  1  synchronous, active-high reset
- MemRead_i  in  1  MEM-stage load control, from EX/MEM
- MemWrite_i  in  1  MEM-stage store control, from EX/MEM
- Addr_i  in  32  ALU result / memory address, from EX/MEM
- WriteData_i  in  32  store data, from EX/MEM
- mem_req_o  out  1  request to data memory, held until ack
- mem_we_o  out  1  1 = write transaction
- mem_addr_o  out  32  latched address
- mem_wdata_o  out  32  latched write data
- mem_ack_i  in  1  memory completion, one-cycle pulse
- mem_rdata_i  in  32  read data, valid with mem_ack_i
- ReadData_o  out  32  captured load data to MEM/WB MemRead_Data_i
- stall_o  out  1  freeze upstream pipeline registers and PC
- memwb_en_o  out  1  MEM/WB enable; equals ~stall_o
- timeout_o  out  1  sticky: an access was aborted by timeout
- stall_cnt_o  out  32  saturating count of stall_o cycles

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE, with MemRead_i|MemWrite_i:
  - latch Addr_i, WriteData_i and we = MemWrite_i
  - clear the wait counter and go to ACCESS
  - otherwise stay in IDLE
- ACCESS:
  - mem_req_o=1; mem_we_o, mem_addr_o and mem_wdata_o come from the latches
  - on mem_ack_i: if ~we, capture mem_rdata_i into ReadData_o; go to DONE
  - otherwise increment the wait counter; when it equals TIMEOUT with no ack, set timeout_o, ReadData_o=0, go to DONE
- DONE: no request; the pipeline advances this cycle. Always go to IDLE, even if the MEM-stage controls are still high; the new instruction is evaluated in IDLE next cycle.
- stall_o = (IDLE & (MemRead_i|MemWrite_i)) | ACCESS, combinational. memwb_en_o = ~stall_o.
- MemRead_i and MemWrite_i both high: treated as a write; ReadData_o=0.
- mem_ack_i outside ACCESS: ignored, with no state or data change.
- ReadData_o holds its value until the next load completes; writes leave it unchanged.
- stall_cnt_o increments every cycle stall_o=1 and saturates at 32'hFFFF_FFFF.
- Wait counter width is $clog2(TIMEOUT+1) and it never wraps.

## Timing
- Reset values, rst_i sampled high at a posedge:
  - state IDLE; mem_req_o 0, mem_we_o 0, mem_addr_o 0, mem_wdata_o 0
  - ReadData_o 0, timeout_o 0, stall_cnt_o 0
  - stall_o and memwb_en_o follow their combinational formulas from IDLE
- Reset during ACCESS abandons the transaction. mem_req_o is 0 in the cycle after that edge, and a late ack is ignored.
- Best case, with ack in the first ACCESS cycle: the instruction occupies MEM for 3 cycles (IDLE-detect, ACCESS, DONE) with 2 stall cycles. MEM/WB captures ReadData_o at the DONE→IDLE edge.
- An ack after N ACCESS cycles gives N+1 stall cycles.
- A timeout gives TIMEOUT+1 stall cycles.
- Back-to-back memory instructions: the second is detected in the IDLE cycle right after DONE, so there are no dead cycles beyond the FSM.
- mem_req_o is registered and never combinationally dependent on mem_ack_i.

## Structure
- Package mem_access_pkg holds:
  - state enum (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2)
  - DATA_W=32 and ADDR_W=32 constants
- One sub-module, mem_wait_timer, contains:
  - clear/enable inputs
  - a saturating counter of $clog2(TIMEOUT+1) bits
  - an expired output (count==TIMEOUT)
- Top level holds the FSM, the request/data latches and stall_cnt_o.

## Test plan
- Load, Addr_i=0x100, memory acks on the 3rd ACCESS cycle with rdata 0xDEADBEEF:
  - stall_o high for 4 cycles; mem_req_o high for 3 cycles
  - ReadData_o=0xDEADBEEF in DONE; memwb_en_o=1 in DONE
  - stall_cnt_o=4
- Store, Addr_i=0x200, WriteData_i=0x12345678, immediate ack:
  - mem_we_o=1, mem_addr_o=0x200, mem_wdata_o=0x12345678 during ACCESS
  - 2 stall cycles; ReadData_o unchanged
- No ack with TIMEOUT=4:
  - mem_req_o high for exactly 4 cycles, then timeout_o=1 (sticky) and ReadData_o=0
  - 5 stall cycles
- Back-to-back loads (0x10, 0x14), each with immediate ack: FSM runs IDLE→ACCESS→DONE→IDLE→ACCESS→DONE with no extra bubbles; each ReadData_o matches its ack data.
- rst_i pulsed on the 2nd ACCESS cycle, then ack the next cycle:
  - all outputs at reset values and mem_req_o=0
  - ack ignored; ReadData_o=0
- Spurious mem_ack_i in IDLE with no request: no state change, stall_o=0, ReadData_o unchanged.
